// File: rtl/mac_seq_pkg.sv
// Shared widths and state encoding for the sequential multiply-accumulate block.
package mac_seq_pkg;

  localparam int unsigned A_W       = 16;
  localparam int unsigned B_W       = 16;
  localparam int unsigned MAX_TERMS = 8;
  localparam int unsigned ACC_W     = A_W + B_W + $clog2(MAX_TERMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_seq_mult.sv
// Registered unsigned multiplier: captures a*b on an enabled edge, otherwise zero.
module mac_seq_mult #(
  parameter int unsigned A_W = mac_seq_pkg::A_W,
  parameter int unsigned B_W = mac_seq_pkg::B_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               enable,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p
);

  localparam int unsigned P_W = A_W + B_W;

  logic [P_W-1:0] p_d;
  logic [P_W-1:0] p_q;

  // A zero product on idle edges lets the accumulator add unconditionally.
  always_comb begin
    p_d = '0;
    if (!clr && enable) begin
      p_d = P_W'(a) * P_W'(b);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/mac_seq.sv
// Sequential dot-product engine: accepts (a,b) beats, accumulates a*b, and
// presents sum/count/truncation until the result is consumed.
module mac_seq #(
  parameter int unsigned A_W       = mac_seq_pkg::A_W,
  parameter int unsigned B_W       = mac_seq_pkg::B_W,
  parameter int unsigned MAX_TERMS = mac_seq_pkg::MAX_TERMS,
  parameter int unsigned ACC_W     = mac_seq_pkg::ACC_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [A_W-1:0]               s_a,
  input  logic [B_W-1:0]               s_b,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ACC_W-1:0]             m_sum,
  output logic [$clog2(MAX_TERMS):0]   m_count,
  output logic                         m_trunc
);

  import mac_seq_pkg::state_e;
  import mac_seq_pkg::IDLE;
  import mac_seq_pkg::ACCUM;
  import mac_seq_pkg::DRAIN;
  import mac_seq_pkg::DONE;

  localparam int unsigned CNT_W = $clog2(MAX_TERMS) + 1;
  localparam int unsigned P_W   = A_W + B_W;

  state_e             state_q,   state_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic               trunc_q,   trunc_d;

  logic               accept;
  logic [CNT_W-1:0]   beat_cnt;
  logic               at_limit;
  logic [P_W-1:0]     prod;

  assign accept   = s_valid && s_ready_q;
  assign beat_cnt = count_q + CNT_W'(1);
  assign at_limit = (beat_cnt == CNT_W'(MAX_TERMS));

  mac_seq_mult #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .enable (accept),
    .a      (s_a),
    .b      (s_b),
    .p      (prod)
  );

  // Next state; the product lands in the accumulator one edge after acceptance.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    trunc_d = trunc_q;
    acc_d   = acc_q + ACC_W'(prod);

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          count_d = beat_cnt;
          if (s_last || at_limit) begin
            state_d = DRAIN;
            trunc_d = at_limit && !s_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        acc_d = acc_q;
        if (m_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      trunc_d = 1'b0;
    end

    s_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    m_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      trunc_q   <= trunc_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_sum   = acc_q;
  assign m_count = count_q;
  assign m_trunc = trunc_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with hand-computed expected results.
module tb_mac_seq;

  localparam int unsigned A_W       = 16;
  localparam int unsigned B_W       = 16;
  localparam int unsigned MAX_TERMS = 8;
  localparam int unsigned ACC_W     = 35;
  localparam int unsigned CNT_W     = $clog2(MAX_TERMS) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic             s_valid;
  logic             s_ready;
  logic [A_W-1:0]   s_a;
  logic [B_W-1:0]   s_b;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_sum;
  logic [CNT_W-1:0] m_count;
  logic             m_trunc;

  int tests  = 0;
  int failed = 0;

  mac_seq #(
    .A_W       (A_W),
    .B_W       (B_W),
    .MAX_TERMS (MAX_TERMS),
    .ACC_W     (ACC_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sum   (m_sum),
    .m_count (m_count),
    .m_trunc (m_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic consume();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  logic [ACC_W-1:0] held;

  initial begin
    reset = 1'b1; clr = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
    s_last = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_sum",   64'(m_sum),   64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    check("rst_m_trunc", 64'(m_trunc), 64'd0);

    // Three-term dot product with an idle gap between beats.
    send(16'd1, 16'd3, 1'b0);
    tick();
    check("gap_s_ready", 64'(s_ready), 64'd1);
    send(16'd2, 16'd16, 1'b0);
    send(16'd3, 16'd512, 1'b1);
    check("dot3_drain_valid", 64'(m_valid), 64'd0);
    check("dot3_drain_ready", 64'(s_ready), 64'd0);
    tick();
    check("dot3_valid", 64'(m_valid), 64'd1);
    check("dot3_sum",   64'(m_sum),   64'd1571);
    check("dot3_count", 64'(m_count), 64'd3);
    check("dot3_trunc", 64'(m_trunc), 64'd0);
    consume();
    check("dot3_consumed_valid", 64'(m_valid), 64'd0);
    check("dot3_consumed_sum",   64'(m_sum),   64'd0);
    check("dot3_consumed_ready", 64'(s_ready), 64'd1);

    // Term limit without s_last truncates.
    for (int i = 0; i < 8; i++) begin
      send(16'hFFFF, 16'hFFFF, 1'b0);
      if (i == 6) check("lim_ready_beat7", 64'(s_ready), 64'd1);
    end
    check("lim_ready_beat8", 64'(s_ready), 64'd0);
    tick();
    check("lim_valid", 64'(m_valid), 64'd1);
    check("lim_sum",   64'(m_sum),   64'd34358689800);
    check("lim_count", 64'(m_count), 64'd8);
    check("lim_trunc", 64'(m_trunc), 64'd1);

    // Result held under backpressure while a beat is offered.
    held    = m_sum;
    s_valid = 1'b1; s_a = 16'd9; s_b = 16'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_sum",   64'(m_sum),   64'(held));
      check("hold_ready", 64'(s_ready), 64'd0);
    end
    check("hold_count", 64'(m_count), 64'd8);
    consume();
    s_valid = 1'b0;
    check("hold_released_valid", 64'(m_valid), 64'd0);
    check("hold_released_count", 64'(m_count), 64'd0);
    check("hold_released_trunc", 64'(m_trunc), 64'd0);
    check("hold_released_ready", 64'(s_ready), 64'd1);

    // Clear aborts a partial product, overriding a simultaneous beat.
    send(16'd7, 16'd7, 1'b0);
    send(16'd9, 16'd9, 1'b0);
    clr = 1'b1; s_valid = 1'b1; s_a = 16'd100; s_b = 16'd100; s_last = 1'b1;
    tick();
    clr = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check("clr_sum",   64'(m_sum),   64'd0);
    check("clr_count", 64'(m_count), 64'd0);
    check("clr_ready", 64'(s_ready), 64'd1);
    send(16'd4, 16'd5, 1'b1);
    tick();
    check("clr_valid", 64'(m_valid), 64'd1);
    check("clr_sum2",  64'(m_sum),   64'd20);
    check("clr_count2", 64'(m_count), 64'd1);
    consume();

    // Asynchronous reset while draining discards the result.
    send(16'd5, 16'd6, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(m_valid), 64'd0);
    check("arst_sum",   64'(m_sum),   64'd0);
    check("arst_count", 64'(m_count), 64'd0);
    check("arst_trunc", 64'(m_trunc), 64'd0);
    check("arst_ready", 64'(s_ready), 64'd1);
    #1 reset = 1'b0;
    tick();
    check("arst_idle_valid", 64'(m_valid), 64'd0);
    send(16'd0, 16'd0, 1'b1);
    tick();
    check("arst_zero_valid", 64'(m_valid), 64'd1);
    check("arst_zero_sum",   64'(m_sum),   64'd0);
    check("arst_zero_count", 64'(m_count), 64'd1);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 The block SHALL have parameter A_W, default 16: unsigned operand A width.
REQ-002 The block SHALL have parameter B_W, default 16: unsigned operand B width.
REQ-003 The block SHALL have parameter MAX_TERMS, default 8: maximum number of terms per dot product.
REQ-004 The block SHALL have parameter ACC_W, default 35: accumulator width, equal to A_W+B_W+clog2(MAX_TERMS).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear, active high; aborts the current operation.
REQ-008 The block SHALL have port s_valid, input, 1 bit: operand beat valid.
REQ-009 The block SHALL have port s_ready, output, 1 bit: operand beat accepted.
REQ-010 The block SHALL have port s_a, input, A_W bits: operand A.
REQ-011 The block SHALL have port s_b, input, B_W bits: operand B.
REQ-012 The block SHALL have port s_last, input, 1 bit: final term of the dot product.
REQ-013 The block SHALL have port m_valid, output, 1 bit: result valid.
REQ-014 The block SHALL have port m_ready, input, 1 bit: result consumed.
REQ-015 The block SHALL have port m_sum, output, ACC_W bits: sum of a*b over all accepted terms.
REQ-016 The block SHALL have port m_count, output, clog2(MAX_TERMS)+1 bits: number of terms accumulated.
REQ-017 The block SHALL have port m_trunc, output, 1 bit: the term limit forced termination.

Function
REQ-018 The state machine SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-019 A beat SHALL transfer on an edge where s_valid and s_ready are both high.
REQ-020 s_ready SHALL be high in IDLE and ACCUM, and low in DRAIN and DONE.
REQ-021 In IDLE, an accepted non-last beat SHALL move to ACCUM, and an accepted last beat SHALL move to DRAIN.
REQ-022 In ACCUM, an accepted beat with s_last high, or the accepted beat that is number MAX_TERMS, SHALL move to DRAIN.
REQ-023 A beat that ends the operation because of the term limit without s_last SHALL set m_trunc to 1.
REQ-024 The product pipeline SHALL register a*b on the accept edge and add it into the accumulator on the next edge, giving 2-edge latency.
REQ-025 DRAIN SHALL last exactly 1 cycle, after which the state is DONE with m_valid high, so m_valid is visible 2 edges after the last-beat accept.
REQ-026 The accumulator SHALL be unsigned and zero-extended, and SHALL never overflow within MAX_TERMS terms.
REQ-027 In DONE, m_sum, m_count and m_trunc SHALL be held stable until m_ready is high.
REQ-028 On an edge with m_valid and m_ready both high, the state SHALL return to IDLE and the accumulator, count and m_trunc SHALL clear.
REQ-029 No operand beat SHALL be accepted in the same cycle that a result is consumed.
REQ-030 clr high SHALL, on the next edge in any state, force IDLE, zero the accumulator, product register and count, and drop m_valid; clr SHALL override a simultaneous beat or result handshake.
REQ-031 s_valid low in ACCUM SHALL hold the state; idle gaps between beats SHALL be allowed.

Reset
REQ-032 reset high SHALL immediately force IDLE, with s_ready=1 once in IDLE, m_valid=0, m_sum=0, m_count=0, m_trunc=0, and the product and accumulator registers at 0.
REQ-033 A reset in any state, including DRAIN and DONE, SHALL discard the partial result.

Structure
REQ-034 Package mac_seq_pkg SHALL hold the state enum type and the default width constants A_W, B_W, MAX_TERMS and ACC_W.
REQ-035 The registered multiplier stage SHALL be a sub-module named mac_seq_mult, with inputs a, b and enable, and a registered product output.

Verification
REQ-036 Beats (1,3), (2,16) and (3,512), last on the third -> m_valid 2 edges later, m_sum=1571, m_count=3, m_trunc=0.
REQ-037 8 beats of (0xFFFF,0xFFFF) with s_last never high -> m_sum=34358689800, m_count=8, m_trunc=1, and s_ready low after beat 8.
REQ-038 Result pending with m_ready low for 5 cycles -> m_sum stable, s_ready=0, and on the m_ready edge -> IDLE.
REQ-039 clr asserted after 2 beats, then single beat (4,5,last) -> m_sum=20, m_count=1.
REQ-040 reset pulsed mid-DRAIN -> all outputs 0 immediately, then single beat (0,0,last) -> m_sum=0, m_count=1.
